// File: rtl/ft_tx_arbiter.sv
// Two-channel packet arbiter feeding the write side of an FT245 out FIFO.
// Each packet is sent as header {4'hC,3'b000,id}, length, then exactly length payload bytes.
module ft_tx_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd1024,
    parameter logic [7:0]  PAD     = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ch0_req,
    input  logic       ch1_req,
    input  logic [7:0] ch0_len,
    input  logic [7:0] ch1_len,
    input  logic       ch0_empty,
    input  logic       ch1_empty,
    input  logic [7:0] ch0_data,
    input  logic [7:0] ch1_data,
    output logic       ch0_rd,
    output logic       ch1_rd,
    output logic       ch0_done,
    output logic       ch1_done,
    input  logic       out_fifo_full,
    output logic       out_fifo_wr,
    output logic [7:0] out_fifo_data,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_err,
    input  logic       clear_err
);

    localparam int unsigned LEN_W   = 8;
    localparam int unsigned STALL_W = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic               id_q, id_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               pad_q, pad_d;
    logic               last_q, last_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic [1:0]         grant_q, grant_d;
    logic [1:0]         done_q, done_d;

    logic               src_empty;
    logic [7:0]         src_data;
    logic               win;

    assign src_empty = id_q ? ch1_empty : ch0_empty;
    assign src_data  = id_q ? ch1_data  : ch0_data;

    // Round-robin: on a tie the channel not granted last wins.
    assign win = (ch0_req && ch1_req) ? ~last_q : ch1_req;

    assign grant       = grant_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;
    assign ch0_done    = done_q[0];
    assign ch1_done    = done_q[1];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            id_q    <= 1'b0;
            len_q   <= '0;
            rem_q   <= '0;
            stall_q <= '0;
            pad_q   <= 1'b0;
            last_q  <= 1'b1;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            grant_q <= 2'b00;
            done_q  <= 2'b00;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            stall_q <= stall_d;
            pad_q   <= pad_d;
            last_q  <= last_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            grant_q <= grant_d;
            done_q  <= done_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        len_d   = len_q;
        rem_d   = rem_q;
        stall_d = stall_q;
        pad_d   = pad_q;
        last_d  = last_q;
        grant_d = grant_q;
        done_d  = 2'b00;
        err_d   = clear_err ? 1'b0 : err_q;

        case (state_q)
            S_IDLE: begin
                if (ch0_req || ch1_req) begin
                    id_d    = win;
                    len_d   = win ? ch1_len : ch0_len;
                    rem_d   = win ? ch1_len : ch0_len;
                    grant_d = win ? 2'b10 : 2'b01;
                    stall_d = '0;
                    pad_d   = 1'b0;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (out_fifo_wr) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (out_fifo_wr) begin
                    if (len_q == '0) begin
                        state_d = S_DONE;
                        done_d  = id_q ? 2'b10 : 2'b01;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (out_fifo_wr) begin
                    rem_d   = rem_q - LEN_W'(1);
                    stall_d = '0;
                    if (rem_q == LEN_W'(1)) begin
                        state_d = S_DONE;
                        done_d  = id_q ? 2'b10 : 2'b01;
                    end
                end else if (!pad_q && src_empty && !out_fifo_full) begin
                    // Starved source: count, then switch to padding; set wins over clear.
                    if (stall_q == TIMEOUT - STALL_W'(1)) begin
                        pad_d   = 1'b1;
                        err_d   = 1'b1;
                        stall_d = '0;
                    end else begin
                        stall_d = stall_q + STALL_W'(1);
                    end
                end
            end
            S_DONE: begin
                last_d  = id_q;
                grant_d = 2'b00;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Combinational strobes toward the sources and the out FIFO
    always_comb begin
        ch0_rd        = 1'b0;
        ch1_rd        = 1'b0;
        out_fifo_wr   = 1'b0;
        out_fifo_data = 8'h00;

        case (state_q)
            S_HDR: begin
                out_fifo_wr   = !out_fifo_full;
                out_fifo_data = {4'hC, 3'b000, id_q};
            end
            S_LEN: begin
                out_fifo_wr   = !out_fifo_full;
                out_fifo_data = len_q;
            end
            S_DATA: begin
                if (pad_q) begin
                    out_fifo_wr   = !out_fifo_full;
                    out_fifo_data = PAD;
                end else begin
                    out_fifo_wr   = !src_empty && !out_fifo_full;
                    out_fifo_data = src_data;
                    ch0_rd        = !id_q && out_fifo_wr;
                    ch1_rd        = id_q && out_fifo_wr;
                end
            end
            default: begin
                out_fifo_wr   = 1'b0;
                out_fifo_data = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Directed bench for ft_tx_arbiter: FWFT source models, out-FIFO capture and
// hand-computed byte streams for each scenario.
module tb_ft_tx_arbiter;

    typedef logic [7:0] bq_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ch0_req = 1'b0, ch1_req = 1'b0;
    logic [7:0] ch0_len = 8'h00, ch1_len = 8'h00;
    logic       ch0_empty, ch1_empty;
    logic [7:0] ch0_data, ch1_data;
    logic       ch0_rd, ch1_rd, ch0_done, ch1_done;
    logic       out_fifo_full = 1'b0;
    logic       out_fifo_wr;
    logic [7:0] out_fifo_data;
    logic [1:0] grant;
    logic       busy, timeout_err;
    logic       clear_err = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    bq_t src0, src1, outq;
    int  wcyc[$];
    int  cyc = 0;
    int  bad_wr = 0;
    int  rd0_cnt = 0, rd1_cnt = 0;
    int  done0_cnt = 0, done1_cnt = 0;
    int  done_cyc = 0;

    ft_tx_arbiter #(.TIMEOUT(16'd8), .PAD(8'hA5)) dut (
        .clk(clk), .rst(rst),
        .ch0_req(ch0_req), .ch1_req(ch1_req),
        .ch0_len(ch0_len), .ch1_len(ch1_len),
        .ch0_empty(ch0_empty), .ch1_empty(ch1_empty),
        .ch0_data(ch0_data), .ch1_data(ch1_data),
        .ch0_rd(ch0_rd), .ch1_rd(ch1_rd),
        .ch0_done(ch0_done), .ch1_done(ch1_done),
        .out_fifo_full(out_fifo_full), .out_fifo_wr(out_fifo_wr),
        .out_fifo_data(out_fifo_data), .grant(grant), .busy(busy),
        .timeout_err(timeout_err), .clear_err(clear_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Sources and out-FIFO monitor: sample mid-cycle, pop just after the edge.
    initial begin
        bit tk0, tk1;
        ch0_empty = 1'b1; ch1_empty = 1'b1;
        ch0_data  = 8'h00; ch1_data = 8'h00;
        forever begin
            @(negedge clk);
            cyc++;
            tk0 = ch0_rd;
            tk1 = ch1_rd;
            if (ch0_rd) rd0_cnt++;
            if (ch1_rd) rd1_cnt++;
            if (out_fifo_wr) begin
                if (out_fifo_full) bad_wr++;
                outq.push_back(out_fifo_data);
                wcyc.push_back(cyc);
            end
            if (ch0_done) begin done0_cnt++; done_cyc = cyc; end
            if (ch1_done) begin done1_cnt++; done_cyc = cyc; end
            @(posedge clk);
            #2;
            if (tk0 && src0.size() > 0) void'(src0.pop_front());
            if (tk1 && src1.size() > 0) void'(src1.pop_front());
            ch0_empty = (src0.size() == 0);
            ch1_empty = (src1.size() == 0);
            ch0_data  = ch0_empty ? 8'h00 : src0[0];
            ch1_data  = ch1_empty ? 8'h00 : src1[0];
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done(input bit ch, input bit toggle);
        bit seen = 1'b0;
        for (int i = 0; i < 64 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (toggle) out_fifo_full = ~out_fifo_full;
            seen = ch ? ch1_done : ch0_done;
        end
        check("done_wait", 32'(seen), 32'd1);
    endtask

    task automatic check_stream(input string tag, input bq_t exp);
        check({tag, "_count"}, 32'(outq.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < outq.size()) check($sformatf("%s_b%0d", tag, i), 32'(outq[i]), 32'(exp[i]));
        end
        outq.delete();
        wcyc.delete();
    endtask

    initial begin
        bq_t e;
        int  gap;

        // Reset state
        step(3);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(timeout_err), 32'd0);
        check("rst_done", 32'({ch1_done, ch0_done}), 32'd0);
        check("rst_strobes", 32'({ch1_rd, ch0_rd, out_fifo_wr}), 32'd0);
        rst = 1'b1;
        step(2);

        // Tie after reset: ch0 first, then ch1 twice while ch0 is idle
        src0 = '{8'h5A};
        src1 = '{8'h6B, 8'h7C};
        ch0_len = 8'd1; ch1_len = 8'd1;
        ch0_req = 1'b1; ch1_req = 1'b1;
        wait_done(1'b0, 1'b0);
        ch0_req = 1'b0;
        wait_done(1'b1, 1'b0);
        wait_done(1'b1, 1'b0);
        ch1_req = 1'b0;
        step(2);
        e = '{8'hC0, 8'h01, 8'h5A, 8'hC1, 8'h01, 8'h6B, 8'hC1, 8'h01, 8'h7C};
        check_stream("tie", e);
        check("tie_done0", 32'(done0_cnt), 32'd1);
        check("tie_done1", 32'(done1_cnt), 32'd2);

        // Single packet, no backpressure
        done0_cnt = 0;
        src0 = '{8'h11, 8'h22, 8'h33};
        ch0_len = 8'd3;
        ch0_req = 1'b1;
        step(1);
        check("single_grant", 32'(grant), 32'd1);
        check("single_busy", 32'(busy), 32'd1);
        wait_done(1'b0, 1'b0);
        ch0_req = 1'b0;
        step(1);
        check("single_idle_grant", 32'(grant), 32'd0);
        check("single_idle_busy", 32'(busy), 32'd0);
        step(1);
        check("single_consec", 32'(wcyc[4] - wcyc[0]), 32'd4);
        e = '{8'hC0, 8'h03, 8'h11, 8'h22, 8'h33};
        check_stream("single", e);
        check("single_done", 32'(done0_cnt), 32'd1);

        // Backpressure: full alternates every cycle
        rd0_cnt = 0;
        src0 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4};
        ch0_len = 8'd4;
        ch0_req = 1'b1;
        out_fifo_full = 1'b1;
        wait_done(1'b0, 1'b1);
        ch0_req = 1'b0;
        out_fifo_full = 1'b0;
        step(2);
        e = '{8'hC0, 8'h04, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
        check_stream("bp", e);
        check("bp_no_wr_full", 32'(bad_wr), 32'd0);
        check("bp_rd", 32'(rd0_cnt), 32'd4);
        check("bp_err", 32'(timeout_err), 32'd0);

        // Timeout: ch1 supplies 2 of 4 bytes, then padding
        rd1_cnt = 0;
        src1 = '{8'hB1, 8'hB2};
        ch1_len = 8'd4;
        ch1_req = 1'b1;
        wait_done(1'b1, 1'b0);
        ch1_req = 1'b0;
        step(2);
        gap = (wcyc.size() > 4) ? wcyc[4] - wcyc[3] : -1;
        check("to_gap", 32'(gap), 32'd9);
        e = '{8'hC1, 8'h04, 8'hB1, 8'hB2, 8'hA5, 8'hA5};
        check_stream("to", e);
        check("to_rd", 32'(rd1_cnt), 32'd2);
        check("to_err_set", 32'(timeout_err), 32'd1);
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        check("to_err_clr", 32'(timeout_err), 32'd0);

        // Zero length: header and length only, no pops
        rd0_cnt = 0;
        src0 = '{8'hEE};
        ch0_len = 8'd0;
        ch0_req = 1'b1;
        wait_done(1'b0, 1'b0);
        ch0_req = 1'b0;
        step(2);
        gap = (wcyc.size() > 1) ? done_cyc - wcyc[1] : -1;
        check("zl_done_after_len", 32'(gap), 32'd1);
        e = '{8'hC0, 8'h00};
        check_stream("zl", e);
        check("zl_rd", 32'(rd0_cnt), 32'd0);
        src0.delete();
        step(1);

        // Reset mid-packet after the header, then a fresh packet
        src0 = '{8'hD1, 8'hD2, 8'hD3};
        ch0_len = 8'd3;
        ch0_req = 1'b1;
        step(2);
        check("mid_pre_wr", 32'(out_fifo_wr), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_wr", 32'(out_fifo_wr), 32'd0);
        check("mid_rst_data", 32'(out_fifo_data), 32'd0);
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rd", 32'({ch1_rd, ch0_rd}), 32'd0);
        step(2);
        outq.delete();
        wcyc.delete();
        rst = 1'b1;
        wait_done(1'b0, 1'b0);
        ch0_req = 1'b0;
        step(2);
        e = '{8'hC0, 8'h03, 8'hD1, 8'hD2, 8'hD3};
        check_stream("mid_restart", e);
        check("all_no_wr_full", 32'(bad_wr), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
